ifq_word_sel: RTL and testbench

- Downstream consumer of the instruction fetch queue's 128-bit line buffer.
- Slices the head line into 32-bit instructions and issues one per cycle, with its PC, through a registered valid/ready output stage toward decode.
- Pulls the buffer head once the last word of a line is issued.
- On a front-end redirect, restarts mid-line at the word offset of the redirect PC.

---
 rtl/ifq_pkg.sv | 36 +++
 rtl/ifq_word_sel_if.sv | 38 +++
 rtl/ifq_out_reg.sv | 86 ++++++++
 rtl/ifq_word_sel.sv | 73 +++++++
 tb/tb_ifq_word_sel.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ifq_pkg.sv
// Shared constants and types for the fetch-queue word selector.
// Exports line/instruction geometry, PC word-offset bit positions, the output
// register state encoding, and the opcode constants for control-transfer
// instruction predecode.
package ifq_pkg;

  localparam int unsigned LINE_W         = 128;
  localparam int unsigned INSTR_W        = 32;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned WORDS_PER_LINE = LINE_W / INSTR_W;
  localparam int unsigned INSTR_BYTES    = INSTR_W / 8;
  localparam int unsigned IDX_W          = $clog2(WORDS_PER_LINE);
  localparam int unsigned OFFSET_LSB     = $clog2(INSTR_BYTES);
  localparam int unsigned OFFSET_MSB     = OFFSET_LSB + IDX_W - 1;

  typedef logic [INSTR_W-1:0]                     instr_t;
  typedef logic [WORDS_PER_LINE-1:0][INSTR_W-1:0] line_t;
  typedef logic [ADDR_W-1:0]                      addr_t;
  typedef logic [IDX_W-1:0]                       idx_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // True for branches, JAL and JALR.
  function automatic logic is_cti(input instr_t instr);
    return (instr[6:0] == OPC_BRANCH) || (instr[6:0] == OPC_JAL) ||
           (instr[6:0] == OPC_JALR);
  endfunction

endpackage

// File: rtl/ifq_word_sel_if.sv
// Bus bundle between the fetch queue / redirect logic, the word selector and
// decode.
// slave  : word selector view (consumes line + redirect, produces instructions)
// master : environment view (fetch queue, redirect source and decode)
// Optional: IFQ_WORD_SEL_PREDECODE_EN adds instr_is_cti.
interface ifq_word_sel_if;
  import ifq_pkg::*;

  logic   flush;
  addr_t  flush_pc;
  line_t  line_data;
  logic   line_empty;
  logic   line_pull;
  instr_t instr_out;
  addr_t  instr_pc;
  logic   instr_valid;
  logic   instr_ready;
`ifdef IFQ_WORD_SEL_PREDECODE_EN
  logic   instr_is_cti;
`endif

  modport slave (
    input  flush, flush_pc, line_data, line_empty, instr_ready,
    output line_pull, instr_out, instr_pc, instr_valid
`ifdef IFQ_WORD_SEL_PREDECODE_EN
    , output instr_is_cti
`endif
  );

  modport master (
    output flush, flush_pc, line_data, line_empty, instr_ready,
    input  line_pull, instr_out, instr_pc, instr_valid
`ifdef IFQ_WORD_SEL_PREDECODE_EN
    , input instr_is_cti
`endif
  );

endinterface

// File: rtl/ifq_out_reg.sv
// Valid/ready output register toward decode.
// Ports: clk, rst (async, active-high); load/flush/ready control; data_in and
// pc_in captured on load; instr_out/instr_pc/instr_valid registered outputs.
// Optional: IFQ_WORD_SEL_PREDECODE_EN adds registered instr_is_cti.
module ifq_out_reg
  import ifq_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  logic   ready,
  input  instr_t data_in,
  input  addr_t  pc_in,
  output instr_t instr_out,
  output addr_t  instr_pc,
`ifdef IFQ_WORD_SEL_PREDECODE_EN
  output logic   instr_is_cti,
`endif
  output logic   instr_valid
);

  out_state_e state_q, state_d;
  instr_t     data_q, data_d;
  addr_t      pc_q, pc_d;
`ifdef IFQ_WORD_SEL_PREDECODE_EN
  logic       cti_q, cti_d;
`endif

  // State and payload registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      pc_q    <= '0;
`ifdef IFQ_WORD_SEL_PREDECODE_EN
      cti_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
`ifdef IFQ_WORD_SEL_PREDECODE_EN
      cti_q   <= cti_d;
`endif
    end
  end

  // Next state: flush beats load, load beats a drain handshake.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OUT_EMPTY;
    end else if (load) begin
      state_d = OUT_FULL;
    end else if (ready && (state_q == OUT_FULL)) begin
      state_d = OUT_EMPTY;
    end
  end

  // Payload capture; held otherwise so outputs stay stable while stalled.
  always_comb begin
    data_d = data_q;
    pc_d   = pc_q;
`ifdef IFQ_WORD_SEL_PREDECODE_EN
    cti_d  = cti_q;
    if (flush) begin
      cti_d = 1'b0;
    end else if (load) begin
      cti_d = is_cti(data_in);
    end
`endif
    if (!flush && load) begin
      data_d = data_in;
      pc_d   = pc_in;
    end
  end

  assign instr_valid = (state_q == OUT_FULL);
  assign instr_out   = data_q;
  assign instr_pc    = pc_q;
`ifdef IFQ_WORD_SEL_PREDECODE_EN
  assign instr_is_cti = cti_q;
`endif

endmodule

// File: rtl/ifq_word_sel.sv
// Slices the fetch-queue head line into instructions and issues one per cycle
// with its PC; pulls the queue head when the last word of a line is captured;
// restarts mid-line at the redirect PC word offset on flush.
// Ports: clk, rst (async, active-high); bus (ifq_word_sel_if.slave) carrying
// flush/flush_pc, line_data/line_empty/line_pull (combinational) and the
// instr_out/instr_pc/instr_valid/instr_ready decode handshake.
// Parameter RESET_PC: PC of the first instruction after reset.
// Optional: IFQ_WORD_SEL_PREDECODE_EN adds bus.instr_is_cti.
module ifq_word_sel
  import ifq_pkg::*;
#(
  parameter addr_t RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  ifq_word_sel_if.slave bus
);

  idx_t   idx_q, idx_d;
  addr_t  fetch_pc_q, fetch_pc_d;
  logic   load_c;
  logic   valid;
  instr_t out_data;
  addr_t  out_pc;

  // Word index and PC of the next word to issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= RESET_PC[OFFSET_MSB:OFFSET_LSB];
      fetch_pc_q <= RESET_PC;
    end else begin
      idx_q      <= idx_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Load when a word is available and the output slot is free or draining.
  always_comb begin
    idx_d      = idx_q;
    fetch_pc_d = fetch_pc_q;
    load_c     = !bus.flush && !bus.line_empty && (!valid || bus.instr_ready);
    if (bus.flush) begin
      idx_d      = bus.flush_pc[OFFSET_MSB:OFFSET_LSB];
      fetch_pc_d = bus.flush_pc;
    end else if (load_c) begin
      idx_d      = idx_q + IDX_W'(1);
      fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
    end
  end

  assign bus.line_pull = load_c && (idx_q == IDX_W'(WORDS_PER_LINE - 1));

  ifq_out_reg u_out_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (load_c),
    .flush        (bus.flush),
    .ready        (bus.instr_ready),
    .data_in      (bus.line_data[idx_q]),
    .pc_in        (fetch_pc_q),
    .instr_out    (out_data),
    .instr_pc     (out_pc),
`ifdef IFQ_WORD_SEL_PREDECODE_EN
    .instr_is_cti (bus.instr_is_cti),
`endif
    .instr_valid  (valid)
  );

  assign bus.instr_valid = valid;
  assign bus.instr_out   = out_data;
  assign bus.instr_pc    = out_pc;

endmodule

// File: tb/tb_ifq_word_sel.sv
// Directed-vector bench for ifq_word_sel: throughput, stall, mid-line
// redirect, flush racing a handshake, empty drain, PC wrap, async reset and
// (with IFQ_WORD_SEL_PREDECODE_EN) predecode.
module tb_ifq_word_sel;
  import ifq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ifq_word_sel_if bus ();

  ifq_word_sel #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input instr_t d, input addr_t pc);
    check({tag, "_valid"}, 64'(bus.instr_valid), 64'd1);
    check({tag, "_data"},  64'(bus.instr_out),   64'(d));
    check({tag, "_pc"},    64'(bus.instr_pc),    64'(pc));
  endtask

  task automatic expect_pull(input string tag, input logic exp);
    #1;
    check({tag, "_pull"}, 64'(bus.line_pull), 64'(exp));
  endtask

  instr_t d[4];
  instr_t g[4];
  instr_t e[4];
  instr_t h[4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      d[i] = 32'hD000_0000 + 32'(i);
      g[i] = 32'hA000_0010 + 32'(i);
      e[i] = 32'hE000_0100 + 32'(i);
      h[i] = 32'hB000_0200 + 32'(i);
    end
    rst             = 1'b1;
    bus.flush       = 1'b0;
    bus.flush_pc    = '0;
    bus.line_data   = '0;
    bus.line_empty  = 1'b1;
    bus.instr_ready = 1'b0;
    repeat (2) cyc();
    check("rst_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_data",  64'(bus.instr_out),   64'd0);
    check("rst_pc",    64'(bus.instr_pc),    64'd0);
    check("rst_pull",  64'(bus.line_pull),   64'd0);
    rst = 1'b0;

    // Full-rate drain of one line, then the queue goes empty.
    bus.line_data   = {d[3], d[2], d[1], d[0]};
    bus.line_empty  = 1'b0;
    bus.instr_ready = 1'b1;
    expect_pull("d_ld0", 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      expect_out($sformatf("d%0d", k), d[k], 32'(4 * k));
      if (k == 3) bus.line_empty = 1'b1;
      expect_pull($sformatf("d%0d_next", k), k == 2);
    end
    cyc();
    check("empty_valid", 64'(bus.instr_valid), 64'd0);
    expect_pull("empty", 1'b0);

    // Stall with G1 held for three cycles.
    bus.line_data  = {g[3], g[2], g[1], g[0]};
    bus.line_empty = 1'b0;
    expect_pull("g_ld0", 1'b0);
    cyc();
    expect_out("g0", g[0], 32'h10);
    cyc();
    expect_out("g1", g[1], 32'h14);
    bus.instr_ready = 1'b0;
    expect_pull("g_stall", 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      expect_out($sformatf("g1_hold%0d", k), g[1], 32'h14);
      expect_pull($sformatf("g1_hold%0d", k), 1'b0);
    end
    bus.instr_ready = 1'b1;
    expect_pull("g_ld2", 1'b0);
    cyc();
    expect_out("g2", g[2], 32'h18);
    expect_pull("g_ld3", 1'b1);
    cyc();
    expect_out("g3", g[3], 32'h1C);

    // Redirect to 0x108: only E2 and E3 of the next line issue.
    bus.flush      = 1'b1;
    bus.flush_pc   = 32'h0000_0108;
    bus.line_empty = 1'b1;
    expect_pull("fl1", 1'b0);
    cyc();
    bus.flush = 1'b0;
    check("fl1_valid", 64'(bus.instr_valid), 64'd0);
    bus.line_data  = {e[3], e[2], e[1], e[0]};
    bus.line_empty = 1'b0;
    expect_pull("e_ld2", 1'b0);
    cyc();
    expect_out("e2", e[2], 32'h108);
    expect_pull("e_ld3", 1'b1);
    cyc();
    expect_out("e3", e[3], 32'h10C);
    bus.line_data = {h[3], h[2], h[1], h[0]};
    expect_pull("h_ld0", 1'b0);
    cyc();
    expect_out("h0", h[0], 32'h110);
    cyc();
    expect_out("h1", h[1], 32'h114);
    cyc();
    expect_out("h2", h[2], 32'h118);

    // Flush coincides with the H2 handshake and the word-3 load.
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h0000_0200;
    expect_pull("fl2", 1'b0);
    cyc();
    bus.flush = 1'b0;
    check("fl2_valid", 64'(bus.instr_valid), 64'd0);
    bus.line_data = {g[3], g[2], g[1], g[0]};
    expect_pull("k_ld0", 1'b0);
    cyc();
    expect_out("k0", g[0], 32'h200);

    // PC wrap, predecode on word 2/3 and the next line's word 0.
    bus.flush      = 1'b1;
    bus.flush_pc   = 32'hFFFF_FFF8;
    bus.line_empty = 1'b1;
    cyc();
    bus.flush = 1'b0;
    check("fl3_valid", 64'(bus.instr_valid), 64'd0);
    bus.line_data  = {32'h0000_0013, 32'h0000_0063, 32'h1111_1111, 32'h2222_2222};
    bus.line_empty = 1'b0;
    expect_pull("w_ld2", 1'b0);
    cyc();
    expect_out("w2", 32'h0000_0063, 32'hFFFF_FFF8);
`ifdef IFQ_WORD_SEL_PREDECODE_EN
    check("w2_cti", 64'(bus.instr_is_cti), 64'd1);
`endif
    expect_pull("w_ld3", 1'b1);
    cyc();
    expect_out("w3", 32'h0000_0013, 32'hFFFF_FFFC);
`ifdef IFQ_WORD_SEL_PREDECODE_EN
    check("w3_cti", 64'(bus.instr_is_cti), 64'd0);
`endif
    bus.line_data = {32'h3, 32'h2, 32'h1, 32'h0000_006F};
    cyc();
    expect_out("wrap0", 32'h0000_006F, 32'h0);
`ifdef IFQ_WORD_SEL_PREDECODE_EN
    check("wrap0_cti", 64'(bus.instr_is_cti), 64'd1);
`endif

    // Async reset mid-line clears outputs without waiting for an edge.
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus.instr_valid), 64'd0);
    check("arst_data",  64'(bus.instr_out),   64'd0);
    check("arst_pc",    64'(bus.instr_pc),    64'd0);
    check("arst_pull",  64'(bus.line_pull),   64'd0);
`ifdef IFQ_WORD_SEL_PREDECODE_EN
    check("arst_cti",   64'(bus.instr_is_cti), 64'd0);
`endif
    cyc();
    rst = 1'b0;
    cyc();
    expect_out("post_rst", 32'h0000_006F, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
